// File: rtl/module_types.sv
// Shared types for the CDB arbitration slice: result bus format, unit count
// and functional-unit indices.
package module_types;

    localparam int CDB_NUM_FU = 4;
    localparam int ROB_ID_W   = 6;
    localparam int XLEN       = 32;

    typedef enum logic [1:0] {
        FU_BR,
        FU_ALU,
        FU_MUL,
        FU_MEM
    } fu_idx_t;

    typedef struct packed {
        logic                valid;
        logic [ROB_ID_W-1:0] rob_id;
        logic [XLEN-1:0]     data;
    } cdb_output_t;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: returns a one-hot grant for the first set request bit
// at or above start_ptr, wrapping past WIDTH-1.
module rr_picker #(
    parameter int WIDTH = 3,
    parameter int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic [PTR_W-1:0] start_ptr,
    output logic [WIDTH-1:0] grant,
    output logic             found
);

    logic [WIDTH-1:0] rot_req;
    logic [WIDTH-1:0] rot_gnt;

    // Rotate so start_ptr lands on bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot_req = WIDTH'({req, req} >> start_ptr);
        rot_gnt = rot_req & (~rot_req + WIDTH'(1));
        grant   = WIDTH'({rot_gnt, rot_gnt} >> (WIDTH - int'(start_ptr)));
        found   = |req;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: branch unit has fixed priority bounded by a starvation limiter,
// the other units share round-robin. Define CDB_ARB_PERF_EN for per-unit perf counters.
module cdb_arbiter
    import module_types::*;
#(
    parameter int NUM_FU       = CDB_NUM_FU,
    parameter int BR_IDX       = int'(FU_BR),
    parameter int STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  cdb_output_t               fu_cdb_info [NUM_FU],
    output logic [NUM_FU-1:0]         fu_stall,
    output cdb_output_t               cdb_out,
    output logic [$clog2(NUM_FU)-1:0] cdb_src
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]               perf_grant_cnt [NUM_FU],
    output logic [31:0]               perf_stall_cnt [NUM_FU]
`endif
);

    localparam int SRC_W    = $clog2(NUM_FU);
    localparam int GRP_N    = NUM_FU - 1;
    localparam int PTR_W    = idx_w(GRP_N);
    localparam int STARVE_W = idx_w(STARVE_LIMIT + 1);

    // Handshake: fu_cdb_info[i].valid is the request; the result transfers in the
    // cycle valid=1 and fu_stall[i]=0, otherwise the unit holds it unchanged.
    logic [NUM_FU-1:0]   req;
    logic [NUM_FU-1:0]   grant;
    logic [NUM_FU-1:0]   nbr_gnt_fu;
    logic [GRP_N-1:0]    nbr_req;
    logic [GRP_N-1:0]    nbr_pick;
    logic                nbr_found;
    logic                br_req;
    logic                br_win;
    logic                br_granted;
    logic                nbr_granted;

    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    cdb_output_t         cdb_out_q, cdb_out_d;
    logic [SRC_W-1:0]    cdb_src_q, cdb_src_d;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            req[i] = fu_cdb_info[i].valid;
        end
    end

    // The round-robin group holds every unit except the branch unit, in index order.
    for (genvar j = 0; j < GRP_N; j++) begin : g_grp
        localparam int FU = (j < BR_IDX) ? j : j + 1;
        assign nbr_req[j]     = req[FU];
        assign nbr_gnt_fu[FU] = nbr_pick[j];
    end
    assign nbr_gnt_fu[BR_IDX] = 1'b0;

    rr_picker #(
        .WIDTH (GRP_N),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .req       (nbr_req),
        .start_ptr (rr_ptr_q),
        .grant     (nbr_pick),
        .found     (nbr_found)
    );

    assign br_req = req[BR_IDX];
    assign br_win = br_req && ((starve_cnt_q < STARVE_W'(STARVE_LIMIT)) || !nbr_found);

    always_comb begin
        grant = '0;
        if (!flush) begin
            if (br_win) begin
                grant[BR_IDX] = 1'b1;
            end else begin
                grant = nbr_gnt_fu;
            end
        end
        fu_stall = rst ? '0 : (req & ~grant & {NUM_FU{~flush}});
    end

    assign br_granted  = grant[BR_IDX];
    assign nbr_granted = |(grant & nbr_gnt_fu);

    always_comb begin
        cdb_out_d    = '0;
        cdb_src_d    = '0;
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;

        for (int i = 0; i < NUM_FU; i++) begin
            if (grant[i]) begin
                cdb_out_d = fu_cdb_info[i];
                cdb_src_d = SRC_W'(i);
            end
        end

        if (nbr_granted) begin
            for (int k = 0; k < GRP_N; k++) begin
                if (nbr_pick[k]) begin
                    rr_ptr_d = (k == GRP_N - 1) ? '0 : PTR_W'(k + 1);
                end
            end
        end

        // Counts only branch wins that actually held someone else off.
        if (flush || !nbr_found || nbr_granted) begin
            starve_cnt_d = '0;
        end else if (br_granted && (starve_cnt_q < STARVE_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_out_q    <= '0;
            cdb_src_q    <= '0;
            rr_ptr_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            cdb_out_q    <= cdb_out_d;
            cdb_src_q    <= cdb_src_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign cdb_out = cdb_out_q;
    assign cdb_src = cdb_src_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_grant_not_stalled: assert property (@(posedge clk) disable iff (rst) (grant & fu_stall) == '0);

`ifdef CDB_ARB_PERF_EN
    logic [31:0] perf_grant_cnt_q [NUM_FU];
    logic [31:0] perf_grant_cnt_d [NUM_FU];
    logic [31:0] perf_stall_cnt_q [NUM_FU];
    logic [31:0] perf_stall_cnt_d [NUM_FU];

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            perf_grant_cnt_d[i] = perf_grant_cnt_q[i] + {31'b0, grant[i]};
            perf_stall_cnt_d[i] = perf_stall_cnt_q[i] + {31'b0, fu_stall[i]};
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (rst) begin
                perf_grant_cnt_q[i] <= '0;
                perf_stall_cnt_q[i] <= '0;
            end else begin
                perf_grant_cnt_q[i] <= perf_grant_cnt_d[i];
                perf_stall_cnt_q[i] <= perf_stall_cnt_d[i];
            end
        end
    end

    assign perf_grant_cnt = perf_grant_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule
